pwm_frame_scheduler: RTL

PWM_FRAME_SCHEDULER -- requirements
Module: pwm_frame_scheduler

---
 rtl/pwm_frame_scheduler.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/pwm_frame_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pwm_frame_scheduler                                        |
// | Description : Captures DMX slots into a shadow bank and, on the first    |
// |               PWM period start after a dirty frame, streams a snapshot   |
// |               through a gamma LUT into the PWM value registers.          |
// |               Optional feature: define SIGNAL_LOSS_EN to enable the      |
// |               signal-loss blackout (timeout counter and loss flag).      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pwm_frame_scheduler #(
    parameter int PWM_CHANNELS  = 8,
    parameter int START_CHANNEL = 0,
    parameter int LOSS_TIMEOUT  = 48000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  dmx_data,
    input  logic [8:0]  dmx_channel,
    input  logic        write_strobe,
    input  logic        frame_end,
    input  logic        pwm_sync,
    output logic        lut_rd,
    output logic [7:0]  lut_addr,
    input  logic [15:0] lut_data,
    output logic        value_wr,
    output logic [2:0]  value_idx,
    output logic [15:0] value_data,
    output logic        busy,
    output logic        loss
);

    localparam int         c_MAX_CH = 8;
    localparam logic [9:0] c_START  = 10'(START_CHANNEL);
    localparam logic [9:0] c_NCH    = 10'(PWM_CHANNELS);
    localparam logic [2:0] c_LAST_K = 3'(PWM_CHANNELS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t                     r_state_q, w_state_d;
    logic [2:0]                 r_k_q, w_k_d;
    logic [c_MAX_CH-1:0][7:0]   r_shadow_q, w_shadow_d;
    logic [c_MAX_CH-1:0][7:0]   r_snap_q, w_snap_d;
    logic [c_MAX_CH-1:0]        r_dirty_q, w_dirty_d;
    logic                       r_pending_q, w_pending_d;
    logic                       r_wr_q, w_wr_d;
    logic [2:0]                 r_idx_q, w_idx_d;

    logic [9:0]                 w_chan_ext;
    logic [9:0]                 w_offset;
    logic                       w_in_range;
    logic [2:0]                 w_slot;
    logic                       w_start;
    logic                       w_loss_hit;

    // Decode whether the incoming slot belongs to this block and which channel it maps to.
    always_comb begin
        w_chan_ext = {1'b0, dmx_channel};
        w_offset   = w_chan_ext - c_START;
        w_in_range = write_strobe && (w_chan_ext >= c_START) && (w_offset < c_NCH);
        w_slot     = w_offset[2:0];
    end

    // Commit sequencer: one LUT read per channel, then one drain cycle for the last write.
    always_comb begin
        w_state_d = r_state_q;
        w_k_d     = r_k_q;
        w_start   = 1'b0;
        case (r_state_q)
            IDLE: begin
                if (r_pending_q && pwm_sync) begin
                    w_state_d = LOOKUP;
                    w_k_d     = 3'd0;
                    w_start   = 1'b1;
                end
            end
            LOOKUP: begin
                if (r_k_q == c_LAST_K) begin
                    w_state_d = DRAIN;
                end else begin
                    w_k_d = r_k_q + 3'd1;
                end
            end
            DRAIN: begin
                w_state_d = IDLE;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
        lut_rd   = (r_state_q == LOOKUP);
        lut_addr = r_snap_q[r_k_q];
        busy     = (r_state_q != IDLE);
        // The LUT answers one cycle after the read, so the write trails the read by one cycle.
        w_wr_d   = lut_rd;
        w_idx_d  = r_k_q;
    end

    assign value_wr   = r_wr_q;
    assign value_idx  = r_idx_q;
    assign value_data = lut_data;

    // Shadow/snapshot/dirty/pending bookkeeping; a blackout overrides everything else.
    always_comb begin
        w_shadow_d  = r_shadow_q;
        w_snap_d    = r_snap_q;
        w_dirty_d   = r_dirty_q;
        w_pending_d = r_pending_q;
        if (w_start) begin
            w_snap_d    = r_shadow_q;
            w_dirty_d   = '0;
            w_pending_d = 1'b0;
        end
        if (w_in_range) begin
            w_shadow_d[w_slot] = dmx_data;
            w_dirty_d[w_slot]  = 1'b1;
        end
        if (frame_end && (w_dirty_d != '0)) begin
            w_pending_d = 1'b1;
        end
        if (w_loss_hit) begin
            for (int i = 0; i < c_MAX_CH; i++) begin
                w_shadow_d[i] = 8'd0;
            end
            for (int i = 0; i < PWM_CHANNELS; i++) begin
                w_dirty_d[i] = 1'b1;
            end
            w_pending_d = 1'b1;
        end
    end

    // Main state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= IDLE;
            r_k_q       <= 3'd0;
            r_shadow_q  <= '0;
            r_snap_q    <= '0;
            r_dirty_q   <= '0;
            r_pending_q <= 1'b0;
            r_wr_q      <= 1'b0;
            r_idx_q     <= 3'd0;
        end else begin
            r_state_q   <= w_state_d;
            r_k_q       <= w_k_d;
            r_shadow_q  <= w_shadow_d;
            r_snap_q    <= w_snap_d;
            r_dirty_q   <= w_dirty_d;
            r_pending_q <= w_pending_d;
            r_wr_q      <= w_wr_d;
            r_idx_q     <= w_idx_d;
        end
    end

`ifdef SIGNAL_LOSS_EN
    localparam int                 c_CNT_W    = $clog2(LOSS_TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(LOSS_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(LOSS_TIMEOUT);

    logic [c_CNT_W-1:0] r_lcnt_q, w_lcnt_d;
    logic               r_loss_q, w_loss_d;

    // Cycles since the last frame; saturates at the timeout so the blackout fires once.
    always_comb begin
        w_lcnt_d   = r_lcnt_q;
        w_loss_d   = r_loss_q;
        w_loss_hit = 1'b0;
        if (frame_end) begin
            w_lcnt_d = '0;
            w_loss_d = 1'b0;
        end else if (r_lcnt_q != c_CNT_FULL) begin
            w_lcnt_d = r_lcnt_q + 1'b1;
            if (r_lcnt_q == c_CNT_LAST) begin
                w_loss_hit = 1'b1;
                w_loss_d   = 1'b1;
            end
        end
    end

    // Loss timer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lcnt_q <= '0;
            r_loss_q <= 1'b0;
        end else begin
            r_lcnt_q <= w_lcnt_d;
            r_loss_q <= w_loss_d;
        end
    end

    assign loss = r_loss_q;
`else
    // Without the loss feature the last committed values are held forever.
    assign w_loss_hit = 1'b0;
    assign loss       = 1'b0;
`endif

endmodule
`default_nettype wire
